// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_arbiter
// Brief    : Round-robin two-requester front end for the shared FPU, with
//            operand holding, result return and a per-operation watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [OP_W-1:0]   a_op,
    input  logic [ADDR_W-1:0] a_x1,
    input  logic [ADDR_W-1:0] a_x2,
    input  logic [ADDR_W-1:0] a_y,
    input  logic [31:0]       a_data,
    output logic              a_done,
    input  logic              b_req,
    input  logic [OP_W-1:0]   b_op,
    input  logic [ADDR_W-1:0] b_x1,
    input  logic [ADDR_W-1:0] b_x2,
    input  logic [ADDR_W-1:0] b_y,
    input  logic [31:0]       b_data,
    output logic              b_done,
    output logic [31:0]       rsp_data,
    output logic              rsp_cond,
    output logic              rsp_err,
    output logic              timeout_sticky,
    output logic [OP_W-1:0]   fpu_operation,
    output logic [ADDR_W-1:0] fpu_x1,
    output logic [ADDR_W-1:0] fpu_x2,
    output logic [ADDR_W-1:0] fpu_y,
    output logic [31:0]       fpu_in_data,
    output logic              fpu_ready,
    input  logic              fpu_valid,
    input  logic [31:0]       fpu_out_data,
    input  logic              fpu_cond
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner_b;
    logic              r_last_b;
    logic              r_cond_hold;
    logic [WD_W-1:0]   r_wd;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_x1;
    logic [ADDR_W-1:0] r_x2;
    logic [ADDR_W-1:0] r_y;
    logic [31:0]       r_data;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_err;
    logic              r_sticky;
    logic              w_req_any;
    logic              w_pick_b;
    logic              w_wd_expired;

    assign w_req_any    = a_req | b_req;
    // On a tie the requester that did not win last time gets the FPU.
    assign w_pick_b     = b_req & (~a_req | ~r_last_b);
    assign w_wd_expired = (r_wd == c_wd_last);

    assign fpu_operation  = r_op;
    assign fpu_x1         = r_x1;
    assign fpu_x2         = r_x2;
    assign fpu_y          = r_y;
    assign fpu_in_data    = r_data;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign timeout_sticky = r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_b   <= 1'b0;
            r_last_b    <= 1'b1;
            r_cond_hold <= 1'b0;
            r_wd        <= '0;
            r_op        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y         <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner_b <= w_pick_b;
                        r_wd      <= '0;
                        r_op      <= w_pick_b ? b_op   : a_op;
                        r_x1      <= w_pick_b ? b_x1   : a_x1;
                        r_x2      <= w_pick_b ? b_x2   : a_x2;
                        r_y       <= w_pick_b ? b_y    : a_y;
                        r_data    <= w_pick_b ? b_data : a_data;
                    end
                end
                S_BUSY: begin
                    if (fpu_valid) begin
                        r_rsp_data <= fpu_out_data;
                        r_rsp_err  <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_sticky   <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_DONE: begin
                    r_last_b    <= r_owner_b;
                    r_cond_hold <= fpu_cond;
                end
                default: ;
            endcase
        end
    end

    // The FPU updates cond at its valid edge, so DONE forwards the live value.
    always_comb begin
        w_state_next = r_state;
        fpu_ready    = 1'b0;
        a_done       = 1'b0;
        b_done       = 1'b0;
        rsp_cond     = r_cond_hold;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                fpu_ready = 1'b1;
                if (fpu_valid || w_wd_expired) w_state_next = S_DONE;
            end
            S_DONE: begin
                a_done       = ~r_owner_b;
                b_done       = r_owner_b;
                rsp_cond     = fpu_cond;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_arbiter
// Brief    : Self-checking bench: directed vector table, hand sequences and
//            randomized operations checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arbiter;

    localparam int ADDR_W  = 6;
    localparam int OP_W    = 6;
    localparam int TIMEOUT = 8;
    localparam int FW      = OP_W + 3 * ADDR_W + 32;
    localparam logic [OP_W-1:0] FADD = 6'h01;
    localparam logic [OP_W-1:0] FCLT = 6'h0A;

    logic              clk;
    logic              rst;
    logic              a_req, b_req;
    logic [OP_W-1:0]   a_op, b_op;
    logic [ADDR_W-1:0] a_x1, a_x2, a_y, b_x1, b_x2, b_y;
    logic [31:0]       a_data, b_data;
    logic              a_done, b_done;
    logic [31:0]       rsp_data;
    logic              rsp_cond, rsp_err, timeout_sticky;
    logic [OP_W-1:0]   fpu_operation;
    logic [ADDR_W-1:0] fpu_x1, fpu_x2, fpu_y;
    logic [31:0]       fpu_in_data;
    logic              fpu_ready, fpu_valid, fpu_cond;
    logic [31:0]       fpu_out_data;

    // FPU model controls
    int          lat_cfg;
    logic [31:0] rdata_cfg;
    logic        rcond_cfg;
    logic        spur;
    int          busy_cnt;

    int total;
    int bad;
    bit in_done;

    typedef struct {
        logic          ra;
        logic          rb;
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        int            lat;
        logic [31:0]   rdata;
        logic          rcond;
        logic          mid;
        logic          exp_b;
        int            exp_ready;
        logic [31:0]   exp_data;
        logic          exp_err;
        logic          exp_cond;
        logic          exp_sticky;
    } vec_t;

    vec_t tbl[9];

    fpu_issue_arbiter #(.ADDR_W(ADDR_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_op(a_op), .a_x1(a_x1), .a_x2(a_x2), .a_y(a_y),
        .a_data(a_data), .a_done(a_done),
        .b_req(b_req), .b_op(b_op), .b_x1(b_x1), .b_x2(b_x2), .b_y(b_y),
        .b_data(b_data), .b_done(b_done),
        .rsp_data(rsp_data), .rsp_cond(rsp_cond), .rsp_err(rsp_err),
        .timeout_sticky(timeout_sticky),
        .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready),
        .fpu_valid(fpu_valid), .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU: valid after lat_cfg ready-high cycles (0 = never); cond changes at the valid edge.
    assign fpu_valid    = spur | (fpu_ready && lat_cfg != 0 && busy_cnt == lat_cfg - 1);
    assign fpu_out_data = rdata_cfg;

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            fpu_cond <= 1'b0;
        end else begin
            if (fpu_valid && fpu_ready) fpu_cond <= rcond_cfg;
            busy_cnt <= fpu_ready ? busy_cnt + 1 : 0;
        end
    end

    function automatic logic [FW-1:0] mkf(input logic [OP_W-1:0] op, input int x1,
                                         input int x2, input int y, input logic [31:0] d);
        return {op, ADDR_W'(x1), ADDR_W'(x2), ADDR_W'(y), d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v);
        int          cyc;
        int          rdy;
        bit          seen;
        logic [FW-1:0] expf;
        expf = v.exp_b ? v.fb : v.fa;
        a_req = v.ra;
        b_req = v.rb;
        {a_op, a_x1, a_x2, a_y, a_data} = v.fa;
        {b_op, b_x1, b_x2, b_y, b_data} = v.fb;
        lat_cfg   = v.lat;
        rdata_cfg = v.rdata;
        rcond_cfg = v.rcond;
        cyc  = 0;
        rdy  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (fpu_ready) begin
                rdy++;
                chk("fpu_fields", 64'({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data}),
                    64'(expf));
                if (v.mid && rdy == 1) begin
                    a_x1 = a_x1 + 6'd6;
                    b_x1 = b_x1 + 6'd6;
                end
            end
            if (a_done || b_done) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_seen", 64'(0), 64'(1));
            in_done = 1'b0;
            return;
        end
        chk("done_owner", 64'({a_done, b_done}), 64'(v.exp_b ? 2'b01 : 2'b10));
        chk("ready_cycles", 64'(rdy), 64'(v.exp_ready));
        chk("latency", 64'(cyc), 64'(v.exp_ready + 1 + int'(in_done)));
        chk("ready_low_in_done", 64'(fpu_ready), 64'(0));
        chk("rsp_data", 64'(rsp_data), 64'(v.exp_data));
        chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
        chk("rsp_cond", 64'(rsp_cond), 64'(v.exp_cond));
        chk("sticky", 64'(timeout_sticky), 64'(v.exp_sticky));
        a_req   = 1'b0;
        b_req   = 1'b0;
        in_done = 1'b1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        spur  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(fpu_ready), 64'(0));
        chk("rst_done", 64'({a_done, b_done}), 64'(0));
        chk("rst_data", 64'(rsp_data), 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        chk("rst_sticky", 64'(timeout_sticky), 64'(0));
        rst     = 1'b0;
        in_done = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        in_done = 1'b0;
        rst = 1'b1;
        spur = 1'b0;
        lat_cfg = 0;
        rdata_cfg = '0;
        rcond_cfg = 1'b0;
        a_req = 0; b_req = 0;
        {a_op, a_x1, a_x2, a_y, a_data} = '0;
        {b_op, b_x1, b_x2, b_y, b_data} = '0;

        //          ra rb fa                                       fb                                        lat rdata         c  mid expb rdy data         err cond sticky
        tbl[0] = '{1, 1, mkf(FADD, 1, 2, 3, 32'h0),                mkf(FCLT, 7, 8, 9, 32'h0),                 1, 32'h11111111, 0, 0, 0, 1, 32'h11111111, 0, 0, 0};
        tbl[1] = '{1, 1, mkf(FADD, 1, 2, 3, 32'h0),                mkf(FCLT, 7, 8, 9, 32'h0),                 3, 32'h00000001, 1, 0, 1, 3, 32'h00000001, 0, 1, 0};
        tbl[2] = '{1, 1, mkf(FADD, 1, 2, 3, 32'h0),                mkf(FCLT, 7, 8, 9, 32'h0),                 2, 32'h33333333, 0, 0, 0, 2, 32'h33333333, 0, 0, 0};
        tbl[3] = '{1, 1, mkf(FADD, 1, 2, 3, 32'h0),                mkf(FCLT, 7, 8, 9, 32'h0),                 1, 32'h00000001, 1, 0, 1, 1, 32'h00000001, 0, 1, 0};
        tbl[4] = '{1, 0, mkf(FADD, 3, 4, 5, 32'h0),                mkf(FCLT, 1, 1, 1, 32'h0),                 2, 32'h40400000, 0, 1, 0, 2, 32'h40400000, 0, 0, 0};
        tbl[5] = '{1, 0, mkf(6'h02, 10, 11, 12, 32'hdeadbeef),     mkf(FCLT, 1, 1, 1, 32'h0),                 0, 32'h55555555, 1, 0, 0, 8, 32'h0,        1, 0, 1};
        tbl[6] = '{0, 1, mkf(FADD, 1, 1, 1, 32'h0),                mkf(FCLT, 20, 21, 22, 32'h3f800000),       4, 32'hcafef00d, 0, 0, 1, 4, 32'hcafef00d, 0, 0, 1};
        tbl[7] = '{1, 0, mkf(6'h03, 30, 31, 32, 32'h1),            mkf(FCLT, 1, 1, 1, 32'h0),                 8, 32'h12345678, 1, 0, 0, 8, 32'h12345678, 0, 1, 1};
        tbl[8] = '{0, 1, mkf(FADD, 1, 1, 1, 32'h0),                mkf(6'h04, 40, 41, 42, 32'h7),             9, 32'hffffffff, 0, 0, 1, 8, 32'h0,        1, 1, 1};

        do_reset();
        for (int i = 0; i < 9; i++) run_op(tbl[i]);

        // Reset in the middle of a hung operation, spurious valid in IDLE, then a clean op.
        a_req = 1'b1;
        {a_op, a_x1, a_x2, a_y, a_data} = mkf(FADD, 5, 6, 7, 32'h0);
        lat_cfg = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("midop_busy", 64'(fpu_ready), 64'(1));
        rst   = 1'b1;
        a_req = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_rst_ready", 64'(fpu_ready), 64'(0));
        chk("midop_rst_done", 64'({a_done, b_done}), 64'(0));
        chk("midop_rst_sticky", 64'(timeout_sticky), 64'(0));
        rst  = 1'b0;
        spur = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("spur_ready", 64'(fpu_ready), 64'(0));
            chk("spur_done", 64'({a_done, b_done}), 64'(0));
        end
        spur    = 1'b0;
        in_done = 1'b0;
        run_op('{1, 0, mkf(FADD, 3, 4, 5, 32'h0), mkf(FCLT, 1, 1, 1, 32'h0),
                 3, 32'h40400000, 0, 0, 0, 3, 32'h40400000, 0, 0, 0});

        // Randomized operations against a transaction-level model.
        do_reset();
        begin
            bit m_last_b;
            bit m_cond;
            bit m_sticky;
            m_last_b = 1'b1;
            m_cond   = 1'b0;
            m_sticky = 1'b0;
            for (int i = 0; i < 40; i++) begin
                vec_t v;
                v.ra = 1'($urandom_range(0, 1));
                v.rb = 1'($urandom_range(0, 1));
                if (!v.ra && !v.rb) v.rb = 1'b1;
                v.fa    = FW'({$urandom(), $urandom()});
                v.fb    = FW'({$urandom(), $urandom()});
                v.lat   = int'($urandom_range(0, 10));
                v.rdata = $urandom();
                v.rcond = 1'($urandom_range(0, 1));
                v.mid   = 1'($urandom_range(0, 1));
                if (v.ra && v.rb) v.exp_b = ~m_last_b;
                else              v.exp_b = v.rb;
                if (v.lat >= 1 && v.lat <= TIMEOUT) begin
                    v.exp_ready = v.lat;
                    v.exp_data  = v.rdata;
                    v.exp_err   = 1'b0;
                    m_cond      = v.rcond;
                end else begin
                    v.exp_ready = TIMEOUT;
                    v.exp_data  = '0;
                    v.exp_err   = 1'b1;
                    m_sticky    = 1'b1;
                end
                v.exp_cond   = m_cond;
                v.exp_sticky = m_sticky;
                m_last_b     = v.exp_b;
                run_op(v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
